// File: rtl/sc_shift_sequencer_if.sv
// Handshake and data bus between the datapath mux stage and the shift sequencer.
// The master drives the command and load data, and the slave returns the result and status.
interface sc_shift_sequencer_if #(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int SHAMT_WIDTH      = $clog2(NUMBER_DATAWIDTH) + 1
);
  logic                        SC_SHIFTSEQ_start_In;
  logic                        SC_SHIFTSEQ_dir_In;
  logic [SHAMT_WIDTH-1:0]      SC_SHIFTSEQ_shamt_InBUS;
  logic                        SC_SHIFTSEQ_serial_In;
  logic [NUMBER_DATAWIDTH-1:0] SC_SHIFTSEQ_data_InBUS;
  logic [NUMBER_DATAWIDTH-1:0] SC_SHIFTSEQ_data_OutBUS;
  logic                        SC_SHIFTSEQ_busy_Out;
  logic                        SC_SHIFTSEQ_done_Out;

  modport master (
    output SC_SHIFTSEQ_start_In, SC_SHIFTSEQ_dir_In, SC_SHIFTSEQ_shamt_InBUS,
           SC_SHIFTSEQ_serial_In, SC_SHIFTSEQ_data_InBUS,
    input  SC_SHIFTSEQ_data_OutBUS, SC_SHIFTSEQ_busy_Out, SC_SHIFTSEQ_done_Out
  );

  modport slave (
    input  SC_SHIFTSEQ_start_In, SC_SHIFTSEQ_dir_In, SC_SHIFTSEQ_shamt_InBUS,
           SC_SHIFTSEQ_serial_In, SC_SHIFTSEQ_data_InBUS,
    output SC_SHIFTSEQ_data_OutBUS, SC_SHIFTSEQ_busy_Out, SC_SHIFTSEQ_done_Out
  );
endinterface

// File: rtl/sc_shift_sequencer.sv
// Loadable universal shift register with an IDLE/SHIFT/DONE sequencer.
// The sequencer loads the mux output, shifts it one bit per clock by a clamped amount, and then pulses done.
module sc_shift_sequencer #(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int SHAMT_WIDTH      = $clog2(NUMBER_DATAWIDTH) + 1
) (
  input  logic                   SC_SHIFTSEQ_CLOCK_50,
  input  logic                   SC_SHIFTSEQ_RESET_InLow,
  sc_shift_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                      state_r;
  logic [NUMBER_DATAWIDTH-1:0] dataReg_r;
  logic                        dirReg_r;
  logic [SHAMT_WIDTH-1:0]      count_r;
  logic                        busy_r;
  logic                        done_r;
  logic [SHAMT_WIDTH-1:0]      clampAmt_s;

  // Amounts beyond the register width would only refill it with serial bits, so saturate.
  function automatic logic [SHAMT_WIDTH-1:0] clampShamt(input logic [SHAMT_WIDTH-1:0] shamt);
    if (shamt > SHAMT_WIDTH'(NUMBER_DATAWIDTH)) begin
      return SHAMT_WIDTH'(NUMBER_DATAWIDTH);
    end else begin
      return shamt;
    end
  endfunction

  function automatic logic [NUMBER_DATAWIDTH-1:0] shiftOnce(
    input logic [NUMBER_DATAWIDTH-1:0] data,
    input logic                        dirRight,
    input logic                        serialBit
  );
    if (dirRight) begin
      return {serialBit, data[NUMBER_DATAWIDTH-1:1]};
    end else begin
      return {data[NUMBER_DATAWIDTH-2:0], serialBit};
    end
  endfunction

  assign clampAmt_s = clampShamt(bus.SC_SHIFTSEQ_shamt_InBUS);

  // Sequencer state, shift register and registered status outputs
  always_ff @(posedge SC_SHIFTSEQ_CLOCK_50 or negedge SC_SHIFTSEQ_RESET_InLow) begin
    if (!SC_SHIFTSEQ_RESET_InLow) begin
      state_r   <= IDLE;
      dataReg_r <= {NUMBER_DATAWIDTH{1'b0}};
      dirReg_r  <= 1'b0;
      count_r   <= {SHAMT_WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.SC_SHIFTSEQ_start_In) begin
            dataReg_r <= bus.SC_SHIFTSEQ_data_InBUS;
            dirReg_r  <= bus.SC_SHIFTSEQ_dir_In;
            count_r   <= clampAmt_s;
            if (clampAmt_s == {SHAMT_WIDTH{1'b0}}) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= SHIFT;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        SHIFT: begin
          // The serial bit is taken live on every shift edge, not latched at start.
          dataReg_r <= shiftOnce(dataReg_r, dirReg_r, bus.SC_SHIFTSEQ_serial_In);
          count_r   <= count_r - SHAMT_WIDTH'(1);
          if (count_r == SHAMT_WIDTH'(1)) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SC_SHIFTSEQ_data_OutBUS = dataReg_r;
  assign bus.SC_SHIFTSEQ_busy_Out    = busy_r;
  assign bus.SC_SHIFTSEQ_done_Out    = done_r;

endmodule

// File: tb/tb_sc_shift_sequencer.sv
// Self-checking bench for sc_shift_sequencer: it uses a table of vectors, random operations checked against a shift model,
// and hand sequences for the reset, live-serial and busy-protection corner cases.
module tb_sc_shift_sequencer;
  localparam int W = 8;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  sc_shift_sequencer_if #(.NUMBER_DATAWIDTH(W), .SHAMT_WIDTH(S)) bus ();

  sc_shift_sequencer #(.NUMBER_DATAWIDTH(W), .SHAMT_WIDTH(S)) dut (
    .SC_SHIFTSEQ_CLOCK_50    (clk),
    .SC_SHIFTSEQ_RESET_InLow (rstN),
    .bus                     (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         dir;
    logic [S-1:0] shamt;
    logic         serial;
    logic [W-1:0] expOut;
    int           k;
  } vec_t;

  vec_t         vecs[8];
  logic [W-1:0] expQ[$];
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic dir,
                                          input int k, input logic ser);
    logic [W-1:0] r = d;
    for (int i = 0; i < k; i++) begin
      if (dir) r = {ser, r[W-1:1]};
      else     r = {r[W-2:0], ser};
    end
    return r;
  endfunction

  // Issue a one-cycle start and return at the falling edge that follows E0.
  task automatic driveStart(input logic [W-1:0] d, input logic dir, input logic [S-1:0] sh,
                            input logic ser, input logic [W-1:0] exp);
    @(negedge clk);
    bus.SC_SHIFTSEQ_data_InBUS  = d;
    bus.SC_SHIFTSEQ_dir_In      = dir;
    bus.SC_SHIFTSEQ_shamt_InBUS = sh;
    bus.SC_SHIFTSEQ_serial_In   = ser;
    bus.SC_SHIFTSEQ_start_In    = 1'b1;
    expQ.push_back(exp);
    @(negedge clk);
    bus.SC_SHIFTSEQ_start_In    = 1'b0;
  endtask

  // n counts the edges since E0, including E0. The task is entered with n = n0 already elapsed.
  task automatic checkRun(input int k, input int n0, input string tag);
    logic [W-1:0] e;
    for (int n = n0; n <= k + 1; n++) begin
      if (n > n0) @(negedge clk);
      chk({tag, " busy"}, 32'(bus.SC_SHIFTSEQ_busy_Out), 32'(n - 1 < k));
      chk({tag, " done"}, 32'(bus.SC_SHIFTSEQ_done_Out), 32'(n - 1 == k));
    end
    if (expQ.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
      e = 8'h00;
    end else begin
      e = expQ.pop_front();
    end
    chk({tag, " data"}, 32'(bus.SC_SHIFTSEQ_data_OutBUS), 32'(e));
    @(negedge clk);
    chk({tag, " post busy"}, 32'(bus.SC_SHIFTSEQ_busy_Out), 32'd0);
    chk({tag, " post done"}, 32'(bus.SC_SHIFTSEQ_done_Out), 32'd0);
    chk({tag, " post hold"}, 32'(bus.SC_SHIFTSEQ_data_OutBUS), 32'(e));
  endtask

  initial begin
    vecs[0] = '{8'hB5, 1'b0, 4'd3,  1'b0, 8'hA8, 3};
    vecs[1] = '{8'h0F, 1'b1, 4'd2,  1'b1, 8'hC3, 2};
    vecs[2] = '{8'h5A, 1'b0, 4'd0,  1'b0, 8'h5A, 0};
    vecs[3] = '{8'hFF, 1'b0, 4'd15, 1'b0, 8'h00, 8};
    vecs[4] = '{8'h81, 1'b1, 4'd8,  1'b1, 8'hFF, 8};
    vecs[5] = '{8'h3C, 1'b0, 4'd1,  1'b1, 8'h79, 1};
    vecs[6] = '{8'hA5, 1'b1, 4'd9,  1'b0, 8'h00, 8};
    vecs[7] = '{8'h33, 1'b1, 4'd0,  1'b1, 8'h33, 0};

    rstN = 1'b0;
    bus.SC_SHIFTSEQ_start_In    = 1'b0;
    bus.SC_SHIFTSEQ_dir_In      = 1'b0;
    bus.SC_SHIFTSEQ_shamt_InBUS = 4'd0;
    bus.SC_SHIFTSEQ_serial_In   = 1'b0;
    bus.SC_SHIFTSEQ_data_InBUS  = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset data", 32'(bus.SC_SHIFTSEQ_data_OutBUS), 32'd0);
    chk("reset busy", 32'(bus.SC_SHIFTSEQ_busy_Out), 32'd0);
    chk("reset done", 32'(bus.SC_SHIFTSEQ_done_Out), 32'd0);
    rstN = 1'b1;
    @(negedge clk);
    chk("idle busy", 32'(bus.SC_SHIFTSEQ_busy_Out), 32'd0);
    chk("idle done", 32'(bus.SC_SHIFTSEQ_done_Out), 32'd0);

    for (int i = 0; i < 8; i++) begin
      driveStart(vecs[i].data, vecs[i].dir, vecs[i].shamt, vecs[i].serial, vecs[i].expOut);
      checkRun(vecs[i].k, 1, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] d;
      logic         dr;
      logic         sr;
      int           sh;
      int           k;
      d  = W'($urandom);
      dr = 1'($urandom);
      sr = 1'($urandom);
      sh = $urandom_range(0, 15);
      k  = (sh > W) ? W : sh;
      driveStart(d, dr, S'(sh), sr, model(d, dr, k, sr));
      checkRun(k, 1, $sformatf("rnd%0d", i));
    end

    // Serial bit changes between shift edges: 0 <<< 1,0,1 gives 8'h05.
    driveStart(8'h00, 1'b0, 4'd3, 1'b0, 8'h05);
    bus.SC_SHIFTSEQ_serial_In = 1'b1;
    @(negedge clk);
    bus.SC_SHIFTSEQ_serial_In = 1'b0;
    @(negedge clk);
    bus.SC_SHIFTSEQ_serial_In = 1'b1;
    checkRun(3, 3, "liveSerial");

    // Start stays high with new operands through SHIFT and DONE, and only the first result may appear.
    driveStart(8'hB5, 1'b0, 4'd3, 1'b0, 8'hA8);
    bus.SC_SHIFTSEQ_start_In    = 1'b1;
    bus.SC_SHIFTSEQ_data_InBUS  = 8'hF0;
    bus.SC_SHIFTSEQ_dir_In      = 1'b1;
    bus.SC_SHIFTSEQ_shamt_InBUS = 4'd2;
    bus.SC_SHIFTSEQ_serial_In   = 1'b0;
    checkRun(3, 1, "busyProt");
    expQ.push_back(8'h3C);
    @(negedge clk);
    bus.SC_SHIFTSEQ_start_In = 1'b0;
    checkRun(2, 1, "reload");

    // Asynchronous reset in the middle of a shift
    @(negedge clk);
    bus.SC_SHIFTSEQ_data_InBUS  = 8'hFF;
    bus.SC_SHIFTSEQ_dir_In      = 1'b0;
    bus.SC_SHIFTSEQ_shamt_InBUS = 4'd8;
    bus.SC_SHIFTSEQ_serial_In   = 1'b1;
    bus.SC_SHIFTSEQ_start_In    = 1'b1;
    @(negedge clk);
    bus.SC_SHIFTSEQ_start_In = 1'b0;
    @(negedge clk);
    chk("preRst busy", 32'(bus.SC_SHIFTSEQ_busy_Out), 32'd1);
    rstN = 1'b0;
    #1;
    chk("midRst data", 32'(bus.SC_SHIFTSEQ_data_OutBUS), 32'd0);
    chk("midRst busy", 32'(bus.SC_SHIFTSEQ_busy_Out), 32'd0);
    chk("midRst done", 32'(bus.SC_SHIFTSEQ_done_Out), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    chk("postRst busy", 32'(bus.SC_SHIFTSEQ_busy_Out), 32'd0);
    chk("postRst done", 32'(bus.SC_SHIFTSEQ_done_Out), 32'd0);
    chk("postRst data", 32'(bus.SC_SHIFTSEQ_data_OutBUS), 32'd0);
    chk("queue drained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
